// File: rtl/random_arbiter_if.sv
// Client-side bundle for random_arbiter: random source input, per-client
// req/ack handshake, delivered word and status flags.
interface random_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [15:0]        rand_in;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [15:0]        data_out;
  logic               busy;
  logic               stuck;

  modport master (output rand_in, req, input ack, data_out, busy, stuck);
  modport slave  (input rand_in, req, output ack, data_out, busy, stuck);
endinterface

// File: rtl/random_arbiter.sv
// Round-robin sharer of one 16-bit random source with a freshness refill gap
// and stuck-source detection. Define RANDOM_ARBITER_WHITEN_EN to XOR each word with the previous grant's sample.
module random_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRESH_CYCLES = 16,
  parameter int STUCK_CYCLES = 64
) (
  input logic             clk,
  input logic             rst,
  random_arbiter_if.slave bus
);

  localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {REFILL, IDLE} state_t;

  state_t             state;
  logic [7:0]         fresh_cnt;
  logic [WW-1:0]      last_winner;
  logic [WW-1:0]      winner;
  logic [WW-1:0]      sel;
  logic               grant_any;
  logic [15:0]        word;
  logic [15:0]        prev_rand;
  logic [9:0]         same_cnt;
  int unsigned        idx;

  // Search starts one past the last winner and wraps; first asserted bit wins.
  always_comb begin
    grant_any = 1'b0;
    winner    = last_winner;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_winner) + i) % NUM_REQ;
      sel = WW'(idx);
      if (!grant_any && bus.req[sel]) begin
        grant_any = 1'b1;
        winner    = sel;
      end
    end
  end

`ifdef RANDOM_ARBITER_WHITEN_EN
  logic [15:0] prev_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prev_word <= '0;
    else if (state == IDLE && grant_any)
      prev_word <= bus.rand_in;
  end

  assign word = bus.rand_in ^ prev_word;
`else
  assign word = bus.rand_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REFILL;
      fresh_cnt   <= '0;
      last_winner <= WW'(NUM_REQ - 1);
      bus.ack     <= '0;
      bus.data_out <= '0;
      bus.busy    <= 1'b1;
    end else begin
      bus.ack <= '0;
      case (state)
        REFILL: begin
          fresh_cnt <= fresh_cnt + 8'd1;
          if (fresh_cnt + 8'd1 == 8'(FRESH_CYCLES)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        IDLE: begin
          if (grant_any) begin
            bus.ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            bus.data_out <= word;
            last_winner  <= winner;
            fresh_cnt    <= '0;
            state        <= REFILL;
            bus.busy     <= 1'b1;
          end
        end
        default: state <= REFILL;
      endcase
    end
  end

  // Counts consecutive cycles with an unchanged source word; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_rand <= '0;
      same_cnt  <= '0;
    end else begin
      prev_rand <= bus.rand_in;
      if (bus.rand_in == prev_rand) begin
        if (same_cnt != '1)
          same_cnt <= same_cnt + 10'd1;
      end else begin
        same_cnt <= '0;
      end
    end
  end

  assign bus.stuck = (same_cnt >= 10'(STUCK_CYCLES - 1));

endmodule

// File: tb/tb_random_arbiter.sv
// Directed bench for random_arbiter: expected grants are queued when the
// request is driven and compared when the ack pulse appears.
module tb_random_arbiter;

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cnt_en = 1'b0;
  int   passes = 0;
  int   total  = 0;
  int   fails  = 0;
  exp_t sb[$];
  exp_t last_e;
  logic [15:0] model_prev = '0;

  random_arbiter_if #(.NUM_REQ(4)) bus ();

  random_arbiter #(
    .NUM_REQ(4),
    .FRESH_CYCLES(16),
    .STUCK_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_en) bus.rand_in = bus.rand_in + 16'd1;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [15:0] raw);
    exp_t e;
    e.ack = a;
`ifdef RANDOM_ARBITER_WHITEN_EN
    e.data = raw ^ model_prev;
    model_prev = raw;
`else
    e.data = raw;
`endif
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string tag, input int exp_cycles);
    int   n = 0;
    logic b1 = 1'b1;
    logic b2 = 1'b1;
    exp_t e;
    do begin
      b2 = b1;
      b1 = bus.busy;
      tick();
      n++;
    end while (bus.ack == '0 && n < exp_cycles + 8);
    chk({tag, "_latency"}, n, exp_cycles);
    e = sb.pop_front();
    last_e = e;
    chk({tag, "_ack"}, 32'(bus.ack), 32'(e.ack));
    chk({tag, "_data"}, 32'(bus.data_out), 32'(e.data));
    chk({tag, "_busy_at_ack"}, 32'(bus.busy), 32'd1);
    chk({tag, "_busy_pre"}, 32'(b1), 32'd0);
    if (exp_cycles >= 2) chk({tag, "_busy_refill"}, 32'(b2), 32'd1);
  endtask

  initial begin
    bus.req     = 4'b0001;
    bus.rand_in = 16'h0000;
    tick();
    tick();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_stuck", 32'(bus.stuck), 32'd0);

    // 1: first grant after a full refill, counting source
    rst = 1'b0;
    bus.rand_in = 16'd0;
    cnt_en = 1'b1;
    push_exp(4'b0001, bus.rand_in + 16'd16);
    wait_grant("first", 17);
    bus.req = 4'b1111;

    // 2: rotation with all clients requesting
    push_exp(4'b0010, bus.rand_in + 16'd16);
    wait_grant("rr1", 17);
    push_exp(4'b0100, bus.rand_in + 16'd16);
    wait_grant("rr2", 17);
    push_exp(4'b1000, bus.rand_in + 16'd16);
    wait_grant("rr3", 17);

    // 3: wrap from client 3 back to 0, then 3 again
    bus.req = 4'b1001;
    push_exp(4'b0001, bus.rand_in + 16'd16);
    wait_grant("wrap0", 17);
    push_exp(4'b1000, bus.rand_in + 16'd16);
    wait_grant("wrap3", 17);
    bus.req = 4'b0000;

    // 4: request dropped during refill produces nothing
    bus.req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("drop_noack", 32'(bus.ack), 32'd0);
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("drop_idle_noack", 32'(bus.ack), 32'd0);
    end
    chk("drop_busy", 32'(bus.busy), 32'd0);
    chk("drop_hold_data", 32'(bus.data_out), 32'(last_e.data));
    bus.req = 4'b0010;
    push_exp(4'b0010, bus.rand_in);
    wait_grant("idle_grant", 1);
    bus.req = 4'b0000;

    // 5: frozen source raises stuck, grants continue, change clears it
    cnt_en = 1'b0;
    bus.rand_in = 16'hBEEF;
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk($sformatf("stuck_%0d", k), 32'(bus.stuck), (k == 64) ? 32'd1 : 32'd0);
    end
    bus.req = 4'b0001;
    push_exp(4'b0001, 16'hBEEF);
    wait_grant("stuck_grant", 1);
    chk("stuck_held", 32'(bus.stuck), 32'd1);
    bus.req = 4'b0000;
    bus.rand_in = 16'hBEF0;
    tick();
    chk("stuck_clear", 32'(bus.stuck), 32'd0);

    // 6: reset mid-refill, then whitening pair, then reset during ack
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_data", 32'(bus.data_out), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_stuck", 32'(bus.stuck), 32'd0);
    model_prev = '0;
    tick();
    rst = 1'b0;
    bus.rand_in = 16'h1234;
    bus.req = 4'b0001;
    push_exp(4'b0001, 16'h1234);
    wait_grant("w1", 17);
    bus.rand_in = 16'h00FF;
    push_exp(4'b0001, 16'h00FF);
    wait_grant("w2", 17);
    rst = 1'b1;
    #1;
    chk("ack_rst_ack", 32'(bus.ack), 32'd0);
    chk("ack_rst_data", 32'(bus.data_out), 32'd0);
    chk("ack_rst_busy", 32'(bus.busy), 32'd1);
    model_prev = '0;
    tick();
    rst = 1'b0;
    bus.req = 4'b0100;
    bus.rand_in = 16'h5555;
    push_exp(4'b0100, 16'h5555);
    wait_grant("post_rst", 17);
    bus.req = 4'b0000;
    tick();
    chk("ack_pulse_end", 32'(bus.ack), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
